// File: rtl/stack_engine_if.sv
// Command, RAM and status bundle for the stack engine.
// The engine takes the slave modport; the command source/RAM side takes master.
interface stack_engine_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 3
);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_WORDS + 1);
    localparam int unsigned BUS_WIDTH = MAX_WORDS * DATA_WIDTH;

    logic                  start;
    logic                  op;
    logic [CNT_WIDTH-1:0]  count;
    logic [BUS_WIDTH-1:0]  push_data;
    logic                  sp_load;
    logic [ADDR_WIDTH-1:0] sp_load_value;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [ADDR_WIDTH-1:0] sp;
    logic                  busy;
    logic                  done;
    logic [BUS_WIDTH-1:0]  pop_data;
    logic                  wrapped;

    modport slave (
        input  start, op, count, push_data, sp_load, sp_load_value, ram_rdata,
        output ram_addr, ram_wdata, ram_we, ram_re, sp, busy, done, pop_data, wrapped
    );

    modport master (
        output start, op, count, push_data, sp_load, sp_load_value, ram_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_re, sp, busy, done, pop_data, wrapped
    );
endinterface

// File: rtl/stack_engine.sv
// Multi-word push/pop engine over a synchronous single-port RAM.
// All outputs are registered; next values are computed in one combinational block.
module stack_engine #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 3,
    parameter int unsigned SP_RESET   = 0
) (
    input  logic clk,
    input  logic reset,
    stack_engine_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_WORDS + 1);
    localparam int unsigned BW = MAX_WORDS * DATA_WIDTH;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PUSH     = 3'd1;
    localparam logic [2:0] POP      = 3'd2;
    localparam logic [2:0] POP_LAST = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]            state, state_nx;
    logic [CW-1:0]         idx, idx_nx, cnt_q, cnt_nx;
    logic [BW-1:0]         data_q, data_nx, pdata_q, pdata_nx;
    logic [ADDR_WIDTH-1:0] sp_q, sp_nx, addr_q, addr_nx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
    logic                  we_q, we_nx, re_q, re_nx;
    logic                  busy_q, busy_nx, done_q, done_nx, wrap_q, wrap_nx;

    function automatic logic [DATA_WIDTH-1:0] word_of(input logic [BW-1:0] v, input logic [CW-1:0] i);
        word_of = '0;
        for (int unsigned w = 0; w < MAX_WORDS; w++)
            if (CW'(w) == i) word_of = v[w*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [BW-1:0] put_word(input logic [BW-1:0] v, input logic [CW-1:0] i,
                                               input logic [DATA_WIDTH-1:0] d);
        put_word = v;
        for (int unsigned w = 0; w < MAX_WORDS; w++)
            if (CW'(w) == i) put_word[w*DATA_WIDTH +: DATA_WIDTH] = d;
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt_q;
        data_nx  = data_q;
        pdata_nx = pdata_q;
        sp_nx    = sp_q;
        addr_nx  = addr_q;
        wdata_nx = '0;
        we_nx    = 1'b0;
        re_nx    = 1'b0;
        wrap_nx  = wrap_q;

        case (state)
            IDLE: begin
                if (bus.sp_load) begin
                    sp_nx   = bus.sp_load_value;
                    wrap_nx = 1'b0;
                end else if (bus.start && bus.count != '0 && bus.count <= CW'(MAX_WORDS)) begin
                    cnt_nx  = bus.count;
                    data_nx = bus.push_data;
                    if (!bus.op) begin
                        state_nx = PUSH;
                        idx_nx   = bus.count - CW'(1);
                        we_nx    = 1'b1;
                        addr_nx  = sp_q - ADDR_WIDTH'(1);
                        wdata_nx = word_of(bus.push_data, bus.count - CW'(1));
                    end else begin
                        state_nx = POP;
                        idx_nx   = '0;
                        re_nx    = 1'b1;
                        addr_nx  = sp_q;
                        pdata_nx = '0;
                    end
                end
            end
            PUSH: begin
                sp_nx = sp_q - ADDR_WIDTH'(1);
                if (sp_q == '0) wrap_nx = 1'b1;
                if (idx == '0) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx - CW'(1);
                    we_nx    = 1'b1;
                    addr_nx  = sp_q - ADDR_WIDTH'(2);
                    wdata_nx = word_of(data_q, idx - CW'(1));
                end
            end
            POP: begin
                sp_nx = sp_q + ADDR_WIDTH'(1);
                if (sp_q == '1) wrap_nx = 1'b1;
                // Read data lags the read strobe by one cycle.
                if (idx != '0) pdata_nx = put_word(pdata_q, idx - CW'(1), bus.ram_rdata);
                if (idx == cnt_q - CW'(1)) begin
                    state_nx = POP_LAST;
                end else begin
                    idx_nx  = idx + CW'(1);
                    re_nx   = 1'b1;
                    addr_nx = sp_q + ADDR_WIDTH'(1);
                end
            end
            POP_LAST: begin
                pdata_nx = put_word(pdata_q, idx, bus.ram_rdata);
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            pdata_q <= '0;
            sp_q    <= ADDR_WIDTH'(SP_RESET);
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt_q   <= cnt_nx;
            data_q  <= data_nx;
            pdata_q <= pdata_nx;
            sp_q    <= sp_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            we_q    <= we_nx;
            re_q    <= re_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            wrap_q  <= wrap_nx;
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_re    = re_q;
    assign bus.sp        = sp_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pop_data  = pdata_q;
    assign bus.wrapped   = wrap_q;
endmodule
